// File: rtl/lc2k_multicycle_ctrl.sv
// LC2K multicycle control FSM.
// Sequences fetch/decode/exec/mem/wb and counts retired instructions.
module lc2k_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [2:0]       ir_opcode,
  input  logic             alu_eq,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             CONTROL_ALUvalB,
  output logic             alu_op,
  output logic             reg_we,
  output logic             reg_dst_sel,
  output logic [1:0]       reg_wdata_sel,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Outputs decode from state (plus handshake/compare inputs) so that
  // reset clears them at once, even mid memory transaction.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    ir_load         = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 2'd0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr_sel    = 1'b0;
    CONTROL_ALUvalB = 1'b0;
    alu_op          = 1'b0;
    reg_we          = 1'b0;
    reg_dst_sel     = 1'b0;
    reg_wdata_sel   = 2'd0;
    halted          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d = ir_opcode;
        if (ir_opcode == OP_JALR) begin
          state_d = S_WB;
        end else if (ir_opcode == OP_HALT) begin
          pc_write = 1'b1;
          state_d  = S_HALT;
        end else if (ir_opcode == 3'd7) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ADD, OP_NOR: begin
            CONTROL_ALUvalB = 1'b1;
            alu_op          = op_q[0];
            state_d         = S_WB;
          end
          OP_LW, OP_SW: begin
            state_d = S_MEM;
          end
          OP_BEQ: begin
            CONTROL_ALUvalB = 1'b1;
            pc_write        = 1'b1;
            pc_src          = alu_eq ? 2'd1 : 2'd0;
            state_d         = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_write = 1'b1;
        reg_we   = 1'b1;
        state_d  = S_FETCH;
        unique case (op_q)
          OP_LW: begin
            reg_dst_sel   = 1'b1;
            reg_wdata_sel = 2'd1;
          end
          OP_JALR: begin
            reg_dst_sel   = 1'b1;
            reg_wdata_sel = 2'd2;
            pc_src        = 2'd2;
          end
          default: begin
            CONTROL_ALUvalB = 1'b1;
            alu_op          = op_q[0];
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Retired count: one per PC update, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (pc_write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, latched opcode and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Directed bench for lc2k_multicycle_ctrl.
// Inputs change at negedge, outputs sampled 1ns later.
module tb_lc2k_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  ir_opcode = 3'd0;
  logic        alu_eq = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_write, mem_req, mem_we, mem_addr_sel;
  logic        CONTROL_ALUvalB, alu_op, reg_we, reg_dst_sel, halted;
  logic [1:0]  pc_src, reg_wdata_sel;
  logic [31:0] instr_count;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  lc2k_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .ir_opcode(ir_opcode),
    .alu_eq(alu_eq),
    .mem_ready(mem_ready),
    .ir_load(ir_load),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel),
    .CONTROL_ALUvalB(CONTROL_ALUvalB),
    .alu_op(alu_op),
    .reg_we(reg_we),
    .reg_dst_sel(reg_dst_sel),
    .reg_wdata_sel(reg_wdata_sel),
    .halted(halted),
    .instr_count(instr_count)
  );

  // il pw ps mr mw ma vb ao rw rd ws h
  localparam logic [13:0] ZERO   = 14'b0_0_00_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] F_WAIT = 14'b0_0_00_1_0_0_0_0_0_0_00_0;
  localparam logic [13:0] F_RDY  = 14'b1_0_00_1_0_0_0_0_0_0_00_0;
  localparam logic [13:0] D_PW   = 14'b0_1_00_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] E_ADD  = 14'b0_0_00_0_0_0_1_0_0_0_00_0;
  localparam logic [13:0] E_NOR  = 14'b0_0_00_0_0_0_1_1_0_0_00_0;
  localparam logic [13:0] E_BT   = 14'b0_1_01_0_0_0_1_0_0_0_00_0;
  localparam logic [13:0] E_BF   = 14'b0_1_00_0_0_0_1_0_0_0_00_0;
  localparam logic [13:0] M_LW   = 14'b0_0_00_1_0_1_0_0_0_0_00_0;
  localparam logic [13:0] M_SW   = 14'b0_0_00_1_1_1_0_0_0_0_00_0;
  localparam logic [13:0] M_SWR  = 14'b0_1_00_1_1_1_0_0_0_0_00_0;
  localparam logic [13:0] W_ADD  = 14'b0_1_00_0_0_0_1_0_1_0_00_0;
  localparam logic [13:0] W_NOR  = 14'b0_1_00_0_0_0_1_1_1_0_00_0;
  localparam logic [13:0] W_LW   = 14'b0_1_00_0_0_0_0_0_1_1_01_0;
  localparam logic [13:0] W_JALR = 14'b0_1_10_0_0_0_0_0_1_1_10_0;
  localparam logic [13:0] H_ST   = 14'b0_0_00_0_0_0_0_0_0_0_00_1;

  function automatic logic [13:0] obs();
    return {ir_load, pc_write, pc_src, mem_req, mem_we, mem_addr_sel,
            CONTROL_ALUvalB, alu_op, reg_we, reg_dst_sel,
            reg_wdata_sel, halted};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (obs() !== ZERO) begin
      bad++;
      $display("FAIL reset_outs got=%h want=%h", obs(), ZERO);
    end
    total++;
    if (instr_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", instr_count);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      run = (i == 1);
      #1;
      total++;
      if (obs() !== ZERO) begin
        bad++;
        $display("FAIL idle c%0d got=%h want=%h", i, obs(), ZERO);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_alu(input logic [2:0] op);
    logic [13:0] ex[4];
    ex = '{F_RDY, ZERO, op[0] ? E_NOR : E_ADD, op[0] ? W_NOR : W_ADD};
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      ir_opcode = op;
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++;
        $display("FAIL alu%0d c%0d got=%h want=%h", op, i, obs(), ex[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instr_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL alu%0d_cnt got=%0d want=%0d", op, instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw();
    logic [13:0] ex[10];
    logic        mr[10];
    ex = '{F_WAIT, F_WAIT, F_RDY, ZERO, ZERO,
           M_LW, M_LW, M_LW, M_LW, W_LW};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_cnt++;
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i];
      ir_opcode = 3'd2;
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++;
        $display("FAIL lw c%0d got=%h want=%h", i, obs(), ex[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instr_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL lw_cnt got=%0d want=%0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw();
    logic [13:0] ex[5];
    logic        mr[5];
    ex = '{F_RDY, ZERO, ZERO, M_SW, M_SWR};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_cnt++;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      ir_opcode = 3'd3;
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++;
        $display("FAIL sw c%0d got=%h want=%h", i, obs(), ex[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instr_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL sw_cnt got=%0d want=%0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_beq(input logic eq);
    logic [13:0] ex[3];
    ex = '{F_RDY, ZERO, eq ? E_BT : E_BF};
    exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      ir_opcode = 3'd4;
      alu_eq    = eq;
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++;
        $display("FAIL beq%0d c%0d got=%h want=%h", eq, i, obs(), ex[i]);
      end
      @(negedge clk);
    end
    alu_eq = 1'b0;
    total++;
    if (instr_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL beq_cnt got=%0d want=%0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_jalr();
    logic [13:0] ex[3];
    ex = '{F_RDY, ZERO, W_JALR};
    exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      ir_opcode = 3'd5;
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++;
        $display("FAIL jalr c%0d got=%h want=%h", i, obs(), ex[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instr_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL jalr_cnt got=%0d want=%0d", instr_count, exp_cnt);
    end
  endtask

  task automatic test_noop(input logic [2:0] op);
    logic [13:0] ex[2];
    ex = '{F_RDY, D_PW};
    exp_cnt++;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      ir_opcode = op;
      #1;
      total++;
      if (obs() !== ex[i]) begin
        bad++;
        $display("FAIL op%0d c%0d got=%h want=%h", op, i, obs(), ex[i]);
      end
      @(negedge clk);
    end
    total++;
    if (instr_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL op%0d_cnt got=%0d want=%0d", op, instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      ir_opcode = 3'd2;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%b want=1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== ZERO) begin
      bad++;
      $display("FAIL mid_outs got=%h want=%h", obs(), ZERO);
    end
    total++;
    if (instr_count !== 32'd0) begin
      bad++;
      $display("FAIL mid_cnt got=%0d want=0", instr_count);
    end
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_program();
    #1;
    total++;
    if (obs() !== ZERO) begin
      bad++;
      $display("FAIL prog_idle got=%h want=%h", obs(), ZERO);
    end
    @(negedge clk);
    test_alu(3'd0);
    test_noop(3'd7);
    test_noop(3'd6);
    for (int i = 0; i < 6; i++) begin
      run       = i[0];
      mem_ready = 1'b1;
      #1;
      total++;
      if (obs() !== H_ST) begin
        bad++;
        $display("FAIL halt c%0d got=%h want=%h", i, obs(), H_ST);
      end
      @(negedge clk);
    end
    total++;
    if (instr_count !== 32'd3) begin
      bad++;
      $display("FAIL halt_cnt got=%0d want=3", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu(3'd0);
    test_alu(3'd1);
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jalr();
    test_noop(3'd7);
    test_reset_mid();
    test_program();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
